rf_write_arbiter: RTL and testbench

Shares the single register-file write port (in/wad/we) between two writeback requesters: A, the ALU result path, and B, the load/memory result path. Each requester uses a valid/ready handshake. Arbitration is round-robin. The accepted write is registered and presented to the register file one cycle later. The block also exports an in-flight-write mask for hazard logic and a saturating conflict counter for performance inspection.

---
 rtl/rf_write_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Round-robin arbiter sharing one register-file write port between
//            an ALU (A) and a load (B) writeback requester, with a registered
//            write stage, pending-write mask and saturating conflict counter.
//            Optional macro RF_WR_ZERO_LOCK_EN makes register 0 hardwired zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_wad,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [2**ADDR_W-1:0]  pend_mask,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam logic [0:0] PRIO_A = 1'b0;
    localparam logic [0:0] PRIO_B = 1'b1;

    logic [0:0]        prio_q, prio_d;
    logic              grant_a, grant_b;
    logic              wr_commit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_wad_q, rf_wad_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Round-robin priority: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Round-robin priority: next state
    always_comb begin
        prio_d = prio_q;
        if (grant_a) begin
            prio_d = PRIO_B;
        end else if (grant_b) begin
            prio_d = PRIO_A;
        end
    end

    // Round-robin priority: grant outputs
    always_comb begin
        grant_a = rst & ~hold & a_valid & (~b_valid | (prio_q == PRIO_A));
        grant_b = rst & ~hold & b_valid & (~a_valid | (prio_q == PRIO_B));
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign sel_addr = grant_a ? a_addr : b_addr;
    assign sel_data = grant_a ? a_data : b_data;

`ifdef RF_WR_ZERO_LOCK_EN
    // Writes to r0 are accepted on the handshake but never reach the file
    assign wr_commit = (grant_a | grant_b) & (sel_addr != '0);
`else
    assign wr_commit = grant_a | grant_b;
`endif

    always_comb begin
        rf_we_d    = wr_commit;
        rf_wad_d   = wr_commit ? sel_addr : rf_wad_q;
        rf_wdata_d = wr_commit ? sel_data : rf_wdata_q;
        cnt_d      = cnt_q;
        if (a_valid && b_valid && !hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_wad_q   <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_wad_q   <= rf_wad_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (rf_we_q) begin
            pend_mask[rf_wad_q] = 1'b1;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_wad       = rf_wad_q;
    assign rf_wdata     = rf_wdata_q;
    assign conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Self-checking bench for rf_write_arbiter against a transaction
//            level reference model (directed scenarios plus random traffic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we;
    logic [3:0]  rf_wad;
    logic [15:0] rf_wdata, pend_mask;
    logic [7:0]  conflict_cnt;

    logic        a_ready_s, b_ready_s, rf_we_s;
    logic [3:0]  rf_wad_s;
    logic [15:0] rf_wdata_s, pend_mask_s;
    logic [1:0]  conflict_cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_prio = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_wad = '0;
    logic [15:0] m_wdata = '0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;
    logic        e_ga, e_gb;
    logic        r_a, r_b;
    logic [15:0] rf_arr [16];
    bit          lock0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wad(rf_wad), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
    );

    rf_write_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_s),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_s),
        .rf_we(rf_we_s), .rf_wad(rf_wad_s), .rf_wdata(rf_wdata_s),
        .pend_mask(pend_mask_s), .conflict_cnt(conflict_cnt_s)
    );

    // One clock: apply inputs, sample readies mid-cycle, advance model at the edge
    task automatic step(input logic rv, input logic hv,
                        input logic av, input logic [3:0] aad, input logic [15:0] ad,
                        input logic bv, input logic [3:0] bad, input logic [15:0] bd);
        rst = rv; hold = hv;
        a_valid = av; a_addr = aad; a_data = ad;
        b_valid = bv; b_addr = bad; b_data = bd;
        e_ga = rv && !hv && av && (!bv || m_prio == 0);
        e_gb = rv && !hv && bv && (!av || m_prio == 1);
        @(negedge clk);
        r_a = a_ready;
        r_b = b_ready;
        @(posedge clk);
        if (!rv) begin
            m_prio = 0; m_we = 1'b0; m_wad = '0; m_wdata = '0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (av && bv && !hv) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (e_ga) begin
                m_prio = 1;
                m_we = !(lock0 && aad == 4'd0);
                if (m_we) begin m_wad = aad; m_wdata = ad; end
            end else if (e_gb) begin
                m_prio = 0;
                m_we = !(lock0 && bad == 4'd0);
                if (m_we) begin m_wad = bad; m_wdata = bd; end
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        if (rf_we === 1'b1) rf_arr[rf_wad] = rf_wdata;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 4'd3, 16'h1234, 0, 4'd0, 16'h0);
            checks++; if (r_a !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b want 0", r_a); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
            checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
        end
        step(1, 0, 1, 4'd3, 16'h1234, 0, 4'd0, 16'h0);
        checks++; if (r_a !== 1'b1) begin errors++; $display("FAIL first_a_ready got %b want 1", r_a); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL first_rf_we got %b want 1", rf_we); end
        checks++; if (rf_wad !== 4'd3) begin errors++; $display("FAIL first_rf_wad got %0d want 3", rf_wad); end
        checks++; if (rf_wdata !== 16'h1234) begin errors++; $display("FAIL first_rf_wdata got %h want 1234", rf_wdata); end
        checks++; if (pend_mask !== 16'h0008) begin errors++; $display("FAIL first_pend got %h want 0008", pend_mask); end
    endtask

    task automatic test_contention();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 4'd1, 16'hA000 + 16'(i), 1, 4'd2, 16'hB000 + 16'(i));
            checks++; if (r_a !== (i % 2 == 0)) begin errors++; $display("FAIL cont_a_ready[%0d] got %b want %b", i, r_a, (i % 2 == 0)); end
            checks++; if (r_b !== (i % 2 == 1)) begin errors++; $display("FAIL cont_b_ready[%0d] got %b want %b", i, r_b, (i % 2 == 1)); end
            checks++; if (rf_wad !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin errors++; $display("FAIL cont_rf_wad[%0d] got %0d want %0d", i, rf_wad, m_wad); end
            checks++; if (rf_wdata !== m_wdata) begin errors++; $display("FAIL cont_rf_wdata[%0d] got %h want %h", i, rf_wdata, m_wdata); end
        end
        checks++; if (conflict_cnt !== 8'd4) begin errors++; $display("FAIL cont_cnt got %0d want 4", conflict_cnt); end
    endtask

    task automatic test_hold();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        step(1, 0, 1, 4'd4, 16'h0001, 1, 4'd6, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 4'd4, 16'h0011, 1, 4'd6, 16'h0002);
            checks++; if (r_a !== 1'b0 || r_b !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b%b want 00", i, r_a, r_b); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_rf_we[%0d] got %b want 0", i, rf_we); end
            checks++; if (conflict_cnt !== 8'd1) begin errors++; $display("FAIL hold_cnt[%0d] got %0d want 1", i, conflict_cnt); end
        end
        step(1, 0, 1, 4'd4, 16'h0011, 1, 4'd6, 16'h0002);
        checks++; if (r_b !== 1'b1 || r_a !== 1'b0) begin errors++; $display("FAIL hold_resume got a=%b b=%b want a=0 b=1", r_a, r_b); end
        checks++; if (rf_wad !== 4'd6 || rf_we !== 1'b1) begin errors++; $display("FAIL hold_resume_wr got we=%b wad=%0d want we=1 wad=6", rf_we, rf_wad); end
    endtask

    task automatic test_same_addr();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        rf_arr[5] = 16'h0;
        step(1, 0, 1, 4'd5, 16'h00AA, 1, 4'd5, 16'h00BB);
        checks++; if (r_a !== 1'b1 || r_b !== 1'b0) begin errors++; $display("FAIL same_first got a=%b b=%b want a=1 b=0", r_a, r_b); end
        step(1, 0, 0, 4'd0, 16'h0, 1, 4'd5, 16'h00BB);
        checks++; if (r_b !== 1'b1) begin errors++; $display("FAIL same_second got b=%b want 1", r_b); end
        step(1, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        checks++; if (rf_arr[5] !== 16'h00BB) begin errors++; $display("FAIL same_addr_final got %h want 00BB", rf_arr[5]); end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 4'(i + 7), 16'hC000 + 16'(i), 0, 4'd0, 16'h0);
            checks++; if (r_a !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, r_a); end
            checks++; if (rf_we !== 1'b1 || rf_wad !== 4'(i + 7)) begin errors++; $display("FAIL b2b_wr[%0d] got we=%b wad=%0d want we=1 wad=%0d", i, rf_we, rf_wad, i + 7); end
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 4'd1, 16'h1, 1, 4'd2, 16'h2);
            checks++; if (conflict_cnt_s !== 2'(m_cnt2)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, conflict_cnt_s, m_cnt2); end
        end
        checks++; if (conflict_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_final got %0d want 3", conflict_cnt_s); end
    endtask

    task automatic test_zero_lock();
        step(0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
        step(1, 0, 1, 4'd9, 16'h5555, 0, 4'd0, 16'h0);
        step(1, 0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 16'h0);
        checks++; if (r_a !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", r_a); end
`ifdef RF_WR_ZERO_LOCK_EN
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_we got %b want 0", rf_we); end
        checks++; if (pend_mask !== 16'h0) begin errors++; $display("FAIL zero_pend got %h want 0000", pend_mask); end
        checks++; if (rf_wad !== 4'd9 || rf_wdata !== 16'h5555) begin errors++; $display("FAIL zero_hold got wad=%0d data=%h want wad=9 data=5555", rf_wad, rf_wdata); end
`else
        checks++; if (rf_we !== 1'b1 || rf_wad !== 4'd0) begin errors++; $display("FAIL zero_we got we=%b wad=%0d want we=1 wad=0", rf_we, rf_wad); end
        checks++; if (pend_mask !== 16'h0001) begin errors++; $display("FAIL zero_pend got %h want 0001", pend_mask); end
`endif
    endtask

    task automatic test_random();
        logic        pav = 1'b0, pbv = 1'b0, rv, hv;
        logic [3:0]  paa = '0, pba = '0;
        logic [15:0] pad = '0, pbd = '0;
        logic [15:0] ep;
        for (int i = 0; i < 400; i++) begin
            if (!pav && ($urandom % 3 != 0)) begin pav = 1'b1; paa = 4'($urandom); pad = 16'($urandom); end
            if (!pbv && ($urandom % 3 != 0)) begin pbv = 1'b1; pba = 4'($urandom); pbd = 16'($urandom); end
            rv = ($urandom % 40) != 0;
            hv = ($urandom % 5) == 0;
            step(rv, hv, pav, paa, pad, pbv, pba, pbd);
            ep = m_we ? (16'h1 << m_wad) : 16'h0;
            checks++; if (r_a !== e_ga || r_b !== e_gb) begin errors++; $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, r_a, r_b, e_ga, e_gb); end
            checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we[%0d] got %b want %b", i, rf_we, m_we); end
            checks++; if (rf_wad !== m_wad || rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wr[%0d] got %0d/%h want %0d/%h", i, rf_wad, rf_wdata, m_wad, m_wdata); end
            checks++; if (pend_mask !== ep) begin errors++; $display("FAIL rnd_pend[%0d] got %h want %h", i, pend_mask, ep); end
            checks++; if (conflict_cnt !== 8'(m_cnt) || conflict_cnt_s !== 2'(m_cnt2)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, conflict_cnt, conflict_cnt_s, m_cnt, m_cnt2); end
            if (e_ga) pav = 1'b0;
            if (e_gb) pbv = 1'b0;
        end
    endtask

    initial begin
`ifdef RF_WR_ZERO_LOCK_EN
        lock0 = 1'b1;
`else
        lock0 = 1'b0;
`endif
        for (int i = 0; i < 16; i++) rf_arr[i] = '0;
        test_reset();
        test_contention();
        test_hold();
        test_same_addr();
        test_back_to_back();
        test_saturation();
        test_zero_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
